// File: rtl/lms_adapt_ctrl.sv
// lms_adapt_ctrl
// Sequencing and step-size scheduling controller for an LMS adaptive filter.
// Each accepted upstream sample produces one lms_en pulse. The controller then
// waits for the filter's lms_update strobe and accumulates |lms_err| over a
// window of 2^WIN_LOG samples. After every window the shift-based step code u
// moves one step toward finer (u+1) or coarser (u-1) adaptation, clamped to
// [U_MIN, U_MAX]. The controller also flags convergence and aborts when the
// filter stops responding.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start, stop        begin adaptation (IDLE only) / abort from any state
//   freeze             hold u constant while averaging continues
//   thr_lo, thr_hi     unsigned window-average thresholds (refine / coarsen)
//   smp_vld, smp_rdy   upstream sample handshake
//   lms_en             one-cycle enable to the filter
//   lms_update,lms_err filter result strobe and signed error
//   u                  step-size shift code
//   win_avg, avg_vld   last window average |err| and its update pulse
//   converged, timeout convergence level, sticky abort flag
//   busy               controller not idle
module lms_adapt_ctrl #(
  parameter int E_W     = 16,
  parameter int WIN_LOG = 6,
  parameter int U_MIN   = 2,
  parameter int U_MAX   = 12,
  parameter int U_INIT  = 4,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  freeze,
  input  logic [E_W-1:0]        thr_lo,
  input  logic [E_W-1:0]        thr_hi,
  input  logic                  smp_vld,
  output logic                  smp_rdy,
  output logic                  lms_en,
  input  logic                  lms_update,
  input  logic signed [E_W-1:0] lms_err,
  output logic [7:0]            u,
  output logic [E_W-1:0]        win_avg,
  output logic                  avg_vld,
  output logic                  converged,
  output logic                  timeout,
  output logic                  busy
);

  localparam int MAG_W = E_W - 1;
  localparam int ACC_W = MAG_W + WIN_LOG;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_EVAL  = 2'd3;

  logic [1:0]         state;
  logic [ACC_W-1:0]   acc;
  logic [WIN_LOG-1:0] cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [MAG_W-1:0]   mag;
  logic [ACC_W-1:0]   acc_sum;
  logic [7:0]         u_nxt;

  // |v| saturated to MAG_W bits: the most negative input maps to the largest
  // positive magnitude instead of wrapping back to itself.
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [E_W-1:0] v);
    logic signed [E_W-1:0] neg;
    if (v == {1'b1, {MAG_W{1'b0}}}) begin
      return {MAG_W{1'b1}};
    end else if (v[E_W-1]) begin
      neg = -v;
      return neg[MAG_W-1:0];
    end else begin
      return v[MAG_W-1:0];
    end
  endfunction

  // Stage 0: combinational magnitude, accumulation and step decision
  assign mag     = abs_sat(lms_err);
  assign acc_sum = acc + {{WIN_LOG{1'b0}}, mag};
  assign smp_rdy = (state == S_ISSUE);
  assign busy    = (state != S_IDLE);

  // The refine test comes first so an inverted threshold pair still refines.
  // win_avg already holds this window's average while in EVAL.
  always_comb begin
    u_nxt = u;
    if (!freeze && (win_avg < thr_lo) && (u < 8'(U_MAX))) begin
      u_nxt = u + 8'd1;
    end else if (!freeze && (win_avg > thr_hi) && (u > 8'(U_MIN))) begin
      u_nxt = u - 8'd1;
    end
  end

  // Stage 1: registered FSM, counters and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      u         <= 8'(U_INIT);
      lms_en    <= 1'b0;
      avg_vld   <= 1'b0;
      converged <= 1'b0;
      timeout   <= 1'b0;
      win_avg   <= '0;
      acc       <= '0;
      cnt       <= '0;
      to_cnt    <= '0;
    end else begin
      lms_en  <= 1'b0;
      avg_vld <= 1'b0;
      if (stop && (state != S_IDLE)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state     <= S_ISSUE;
              u         <= 8'(U_INIT);
              acc       <= '0;
              cnt       <= '0;
              to_cnt    <= '0;
              converged <= 1'b0;
              timeout   <= 1'b0;
            end
          end
          S_ISSUE: begin
            if (smp_vld) begin
              lms_en <= 1'b1;
              to_cnt <= '0;
              state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (lms_update) begin
              acc    <= acc_sum;
              cnt    <= cnt + 1'b1;
              to_cnt <= '0;
              if (cnt == {WIN_LOG{1'b1}}) begin
                // Publish the average together with avg_vld so both are
                // visible during the single EVAL cycle.
                win_avg <= {1'b0, acc_sum[ACC_W-1:WIN_LOG]};
                avg_vld <= 1'b1;
                state   <= S_EVAL;
              end else begin
                state <= S_ISSUE;
              end
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
              timeout <= 1'b1;
              state   <= S_IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: begin
            u         <= u_nxt;
            converged <= (win_avg < thr_lo) && (u_nxt == 8'(U_MAX));
            acc       <= '0;
            cnt       <= '0;
            state     <= S_ISSUE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/lms_adapt_ctrl.md
Name: lms_adapt_ctrl

Overview:
Sequencing and step-size scheduling controller for the lms adaptive filter. It accepts upstream samples through a valid/ready handshake and issues one `en` pulse per sample to the filter, then waits for the filter's `update`. It averages |err| over fixed windows and moves the shift-based step-size code `u` between limits, which gives coarse-to-fine convergence with detection of convergence and timeout.

Parameters:
E_W, 16, width of filter error input (signed)
WIN_LOG, 6, log2 of samples per averaging window
U_MIN, 2, smallest u (largest step) allowed
U_MAX, 12, largest u (finest step) allowed; must satisfy U_MIN <= U_INIT <= U_MAX <= 21
U_INIT, 4, u loaded at reset and at every start
TO_W, 8, timeout counter width
TIMEOUT, 200, cycles in WAIT without lms_update before abort; 1..2^TO_W-1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous active-low
start  in  1  pulse: begin adaptation (honoured only in IDLE)
stop  in  1  pulse: abort to IDLE from any state
freeze  in  1  level: hold u constant, averaging continues
thr_lo  in  E_W  unsigned average-|err| threshold to refine step (u+1)
thr_hi  in  E_W  unsigned average-|err| threshold to coarsen step (u-1)
smp_vld  in  1  upstream sample (xin/din) valid
smp_rdy  out  1  controller accepts sample
lms_en  out  1  one-cycle enable to filter
lms_update  in  1  filter result strobe
lms_err  in  E_W  filter error, valid when lms_update=1
u  out  8  step-size shift code to filter
win_avg  out  E_W  last window average |err|, zero-extended
avg_vld  out  1  one-cycle pulse when win_avg is updated
converged  out  1  level: last window below thr_lo with u==U_MAX
timeout  out  1  sticky abort flag
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at clk edge) sets: state=IDLE, u=U_INIT, lms_en=0, avg_vld=0, converged=0, timeout=0, win_avg=0. The accumulator, sample counter and timeout counter are all cleared. Reset mid-operation aborts immediately, and a later lms_update is ignored.
- The FSM has four states: IDLE, ISSUE, WAIT, EVAL. smp_rdy=(state==ISSUE), combinational. busy is also combinational from state.
- stop has priority over everything. In any non-IDLE state it moves the FSM to IDLE at the next edge, and lms_en is forced to 0. u, win_avg and converged hold their values.
- IDLE:
  - On start & !stop: go to ISSUE; u<=U_INIT; clear accumulator, sample count, timeout and converged.
  - start while busy is ignored.
- ISSUE: the handshake is smp_vld & smp_rdy in cycle t. lms_en=1 in cycle t+1 only (registered), and the state becomes WAIT in cycle t+1. Without smp_vld the FSM stays in ISSUE indefinitely.
- WAIT:
  - The timeout counter counts cycles spent in WAIT.
  - On lms_update: mag=|lms_err|, saturating, so -2^(E_W-1) gives 2^(E_W-1)-1. The accumulator (E_W-1+WIN_LOG bits unsigned, cannot overflow) adds mag, count increments, and the timeout counter clears. If count was 2^WIN_LOG-1 the next state is EVAL, else ISSUE.
  - If the timeout counter reaches TIMEOUT with no update: timeout<=1, go to IDLE.
  - An lms_update arriving in any state other than WAIT is ignored.
- EVAL (exactly one cycle):
  - avg = acc >> WIN_LOG; win_avg<=avg; avg_vld=1 for this cycle.
  - If !freeze and avg<thr_lo and u<U_MAX: u<=u+1.
  - Else if !freeze and avg>thr_hi and u>U_MIN: u<=u-1.
  - thr_lo is checked first, so if thr_lo>thr_hi the refine branch wins.
  - converged <= (avg<thr_lo) && (u_next==U_MAX).
  - Clear accumulator and count, then go to ISSUE.
- u changes only in EVAL, at most once per window, and is always clamped to [U_MIN,U_MAX].
- Latency: handshake to lms_en is 1 cycle. The last update of a window to avg_vld is 1 cycle.

Test Plan:
Common bench parameters: WIN_LOG=2, TIMEOUT=16, U_INIT=4, U_MIN=2, U_MAX=12. A filter model returns lms_update 3 cycles after lms_en.
1. Reset: hold rst_n=0 for 2 cycles with start=1 -> u=4, busy=0, lms_en=0, timeout=0, smp_rdy=0. Release -> IDLE until a fresh start.
2. Handshake: start, smp_vld=1 constant, lms_err=-100 -> exactly one 1-cycle lms_en per update and smp_rdy low during WAIT. After 4 updates, avg_vld pulses with win_avg=100.
3. Step schedule: thr_lo=50, thr_hi=500, lms_err=±10 -> u goes 4,5,…,12 one step per window and holds at 12; converged=1. Then a window of err=1000 -> u=11, converged=0.
4. Saturation/clamp: 4 updates of err=-32768 -> win_avg=32767. Continued big-error windows take u down to 2 and no lower.
5. Timeout: after one lms_en, withhold lms_update for 16 cycles -> timeout=1, busy=0. A late update is ignored. A new start clears timeout and reloads u=4.
6. Freeze/stop: freeze=1 with err=10 windows -> avg_vld still pulses, u unchanged. stop during WAIT -> busy=0 next cycle and the pending update is ignored. After restart, the first window averages only new samples.
